signed_bcd_conv: RTL and testbench

SIGNED_BCD_CONV -- requirements
Module: signed_bcd_conv

---
 rtl/signed_bcd_conv.sv | 103 ++++++++++
 tb/tb_signed_bcd_conv.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/signed_bcd_conv.sv
// signed_bcd_conv: sequential double-dabble converter from an 8-bit value to sign + three BCD digits
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   in_valid, in_ready  input handshake; in_ready is high only while idle
//   in_data [7:0]       value to convert
//   out_valid, out_ready result handshake; out_valid is high only while a result is held
//   sign                1 = negative input
//   hundreds, tens, ones [3:0] BCD digits of the magnitude
// Config: define SIGNED_BCD_SIGNED_IN_EN for two's-complement input (-128..127);
//         leave it undefined for unsigned input (0..255) with sign tied low.
`ifdef SIGNED_BCD_SIGNED_IN_EN
// adder8: 8-bit adder with carry-in; carry-out and signed overflow flags
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout,
    output logic       ovfl
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    assign ovfl = (a[7] == b[7]) && (s[7] != a[7]);
endmodule
`endif

module signed_bcd_conv (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       sign,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t      state, state_nx;
    logic [7:0]  mag, mag_in;
    logic [2:0]  cnt;
    logic        sign_in;
    logic [2:0]  h_adj;
    logic [3:0]  t_adj, o_adj;
    logic [19:0] sh;
`ifdef SIGNED_BCD_SIGNED_IN_EN
    logic [7:0] neg;
    logic       unused_cout, unused_ovfl;
    // two's-complement negation: ~x + 1; 0x80 negates to 0x80, read as unsigned 128
    adder8 u_neg (
        .a    (~in_data),
        .b    (8'd0),
        .cin  (1'b1),
        .s    (neg),
        .cout (unused_cout),
        .ovfl (unused_ovfl)
    );
    assign sign_in = in_data[7];
    assign mag_in  = in_data[7] ? neg : in_data;
`else
    assign sign_in = 1'b0;
    assign mag_in  = in_data;
`endif
    // hundreds never exceeds 2 for an 8-bit magnitude, so three bits carry it
    assign h_adj = hundreds[2:0] >= 3'd5 ? hundreds[2:0] + 3'd3 : hundreds[2:0];
    assign t_adj = tens >= 4'd5 ? tens + 4'd3 : tens;
    assign o_adj = ones >= 4'd5 ? ones + 4'd3 : ones;
    assign sh    = {h_adj, t_adj, o_adj, mag, 1'b0};
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        state_nx  = state == IDLE ? (in_valid ? CONV : IDLE) :
                    state == CONV ? (cnt == 3'd7 ? DONE : CONV) :
                    state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sign     <= 1'b0;
            hundreds <= 4'd0;
            tens     <= 4'd0;
            ones     <= 4'd0;
            mag      <= 8'd0;
            cnt      <= 3'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                sign                    <= sign_in;
                mag                     <= mag_in;
                {hundreds, tens, ones}  <= 12'd0;
                cnt                     <= 3'd0;
            end else if (state == CONV) begin
                {hundreds, tens, ones, mag} <= sh;
                cnt                         <= cnt + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_signed_bcd_conv.sv
// tb_signed_bcd_conv: randomized and directed bench for signed_bcd_conv against an arithmetic model
module tb_signed_bcd_conv;
    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid, sign;
    logic [7:0] in_data = 8'd0;
    logic [3:0] hundreds, tens, ones;
    int         checks = 0, passed = 0, cyc = 0;
    logic [7:0] exp_q[$];
    int         acc_q[$];
    logic       prev_ov = 1'b0;

    always #5 clk = ~clk;

    signed_bcd_conv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones)
    );

    function automatic logic [12:0] model(input logic [7:0] d);
        int v, m;
`ifdef SIGNED_BCD_SIGNED_IN_EN
        v = d[7] ? int'(d) - 256 : int'(d);
`else
        v = int'(d);
`endif
        m = v < 0 ? -v : v;
        return {(v < 0) ? 1'b1 : 1'b0, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                acc_q.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) prev_ov = 1'b0;
        else begin
            if (out_valid) begin
                if (exp_q.size() == 0) chk("spurious_out_valid", exp_q.size(), 1);
                else begin
                    chk("result_model", {sign, hundreds, tens, ones}, model(exp_q[0]));
                    if (!prev_ov) chk("latency_model", cyc - acc_q[0], 8);
                    chk("in_ready_in_done", in_ready, 0);
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic run_one(input logic [7:0] d, input logic [12:0] exp, input int hold);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 8);
        chk("result", {sign, hundreds, tens, ones}, exp);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
            chk("held", {out_valid, in_ready, sign, hundreds, tens, ones}, {2'b10, exp});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_handshake", {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        int n;
        #1;
        chk("reset_state", {in_ready, out_valid, sign, hundreds, tens, ones}, 15'h4000);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef SIGNED_BCD_SIGNED_IN_EN
        run_one(8'h85, 13'h1123, 0);
        run_one(8'h80, 13'h1128, 0);
        run_one(8'h7F, 13'h0127, 0);
        run_one(8'h00, 13'h0000, 0);
        run_one(8'hFF, 13'h1001, 0);
        run_one(8'h9C, 13'h1100, 5);
`else
        run_one(8'hFF, 13'h0255, 0);
        run_one(8'h80, 13'h0128, 0);
        run_one(8'h00, 13'h0000, 0);
        run_one(8'h9C, 13'h0156, 5);
`endif
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hC4;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {in_ready, out_valid, sign, hundreds, tens, ones}, 15'h4000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("aborted_no_result", n, 0);
        run_one(8'h2A, 13'h0042, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            n = 0;
            while (!in_ready && n < 30) begin
                @(negedge clk);
                n++;
            end
            if (i > 0) chk("sweep_period", n, 9);
            in_valid = 1'b1;
            in_data  = 8'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        repeat (600) begin
            @(negedge clk);
            in_valid  = ($urandom % 3) != 0;
            in_data   = 8'($urandom);
            out_ready = ($urandom % 2) != 0;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (15) @(negedge clk);
        chk("drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
